pipelined_addsub: RTL and testbench

Parametrised, fully pipelined WIDTH-bit adder/subtractor with carry ripple split into SEG-bit segments, one segment per stage. Generalises the fixed 32-bit/8-bit-segment pipelined adder with:
- configurable width and segment size;
- correct per-segment operand skew and result deskew;
- an add/sub mode input and signed overflow flag;
- a valid/ready handshake with backpressure.

It sits between operand sources and any consumer that needs one result per clock at high Fmax.

---
 rtl/pipelined_addsub.sv | 103 ++++++++++
 tb/tb_pipelined_addsub.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: carry ripples one SEG-bit segment per stage, with
// operand skew, result deskew, signed overflow and a valid/ready handshake with backpressure.
module pipelined_addsub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num_a,
    input  logic [WIDTH-1:0] num_b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] SUM,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STAGES = WIDTH / SEG;

    // One global enable: the whole pipe advances unless a result is being held for the consumer.
    logic en;
    assign en       = out_ready || !out_valid;
    assign in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned BW = WIDTH - k * SEG;

        logic             v_q;
        logic             s_q;
        logic             c_q;
        // Segments below k already hold sum bits; segment k and above still hold operand A.
        logic [WIDTH-1:0] w_q;
        // Only the B segments not yet consumed travel down the pipe.
        logic [BW-1:0]    b_q;
        logic [SEG-1:0]   b_seg;
        logic [SEG:0]     seg_sum;
        logic [WIDTH-1:0] w_nxt;

        always_comb begin
            b_seg   = b_q[SEG-1:0] ^ {SEG{s_q}};
            seg_sum = {1'b0, w_q[k*SEG +: SEG]} + {1'b0, b_seg} + {{SEG{1'b0}}, c_q};
            w_nxt   = w_q;
            w_nxt[k*SEG +: SEG] = seg_sum[SEG-1:0];
        end

        if (k == 0) begin : g_load
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    v_q <= 1'b0;
                    s_q <= 1'b0;
                    c_q <= 1'b0;
                    w_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    v_q <= in_valid;
                    s_q <= sub;
                    c_q <= cin;
                    w_q <= num_a;
                    b_q <= num_b;
                end
            end
        end else begin : g_load
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    v_q <= 1'b0;
                    s_q <= 1'b0;
                    c_q <= 1'b0;
                    w_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    v_q <= g_stage[k-1].v_q;
                    s_q <= g_stage[k-1].s_q;
                    c_q <= g_stage[k-1].seg_sum[SEG];
                    w_q <= g_stage[k-1].w_nxt;
                    b_q <= g_stage[k-1].b_q[WIDTH-(k-1)*SEG-1:SEG];
                end
            end
        end

        if (k == STAGES - 1) begin : g_out
            // Carry into the MSB is recovered from the MSB sum bit and its two addend bits.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    out_valid <= 1'b0;
                    SUM       <= '0;
                    cout      <= 1'b0;
                    ovf       <= 1'b0;
                end else if (en) begin
                    out_valid <= v_q;
                    SUM       <= w_nxt;
                    cout      <= seg_sum[SEG];
                    ovf       <= seg_sum[SEG]
                                 ^ (w_q[WIDTH-1] ^ b_seg[SEG-1] ^ seg_sum[SEG-1]);
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: 32/8, 16/4 and 8/8 instances driven in parallel,
// directed vector table, hand sequences, and a randomized scoreboard against an arithmetic model.
module tb_pipelined_addsub;

    localparam int LAT = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic        s;
        logic [31:0] sum;
        logic        co;
        logic        ov;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        out_ready;
    logic        cin;
    logic        sub;
    logic [31:0] op_a;
    logic [31:0] op_b;

    logic        r32, v32, c32, o32;
    logic [31:0] s32;
    logic        r16, v16, c16, o16;
    logic [15:0] s16;
    logic        r8, v8, c8, o8;
    logic [7:0]  s8;

    int checks = 0;
    int errors = 0;
    int acc32  = 0;

    logic [33:0] q32[$];
    logic [33:0] q16[$];
    logic [33:0] q8[$];

    vec_t tbl[10];
    vec_t seq[4];

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(32), .SEG(8)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(r32),
        .num_a(op_a), .num_b(op_b), .cin(cin), .sub(sub),
        .out_valid(v32), .out_ready(out_ready), .SUM(s32), .cout(c32), .ovf(o32)
    );

    pipelined_addsub #(.WIDTH(16), .SEG(4)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(r16),
        .num_a(op_a[15:0]), .num_b(op_b[15:0]), .cin(cin), .sub(sub),
        .out_valid(v16), .out_ready(out_ready), .SUM(s16), .cout(c16), .ovf(o16)
    );

    pipelined_addsub #(.WIDTH(8), .SEG(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(r8),
        .num_a(op_a[7:0]), .num_b(op_b[7:0]), .cin(cin), .sub(sub),
        .out_valid(v8), .out_ready(out_ready), .SUM(s8), .cout(c8), .ovf(o8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain w-bit arithmetic; overflow when like-signed addends give an unlike sign.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input logic s, input int w);
        logic [63:0] mask, av, bv, t;
        logic        co, ov;
        mask = (64'd1 << w) - 64'd1;
        av   = {32'd0, a} & mask;
        bv   = (s ? ~{32'd0, b} : {32'd0, b}) & mask;
        t    = av + bv + {63'd0, c};
        co   = t[w];
        ov   = (av[w-1] == bv[w-1]) && (t[w-1] != av[w-1]);
        return {ov, co, t[31:0] & mask[31:0]};
    endfunction

    always @(negedge clk) begin : mon32
        logic [33:0] e;
        if (reset_n === 1'b1) begin
            if (v32 && out_ready) begin
                e = (q32.size() > 0) ? q32.pop_front() : 'x;
                check("sb32", 64'({o32, c32, s32}), 64'(e));
            end
            if (in_valid && r32) begin
                q32.push_back(model(op_a, op_b, cin, sub, 32));
                acc32++;
            end
        end
    end

    always @(negedge clk) begin : mon16
        logic [33:0] e;
        if (reset_n === 1'b1) begin
            if (v16 && out_ready) begin
                e = (q16.size() > 0) ? q16.pop_front() : 'x;
                check("sb16", 64'({o16, c16, 16'd0, s16}), 64'(e));
            end
            if (in_valid && r16) q16.push_back(model(op_a, op_b, cin, sub, 16));
        end
    end

    always @(negedge clk) begin : mon8
        logic [33:0] e;
        if (reset_n === 1'b1) begin
            if (v8 && out_ready) begin
                e = (q8.size() > 0) ? q8.pop_front() : 'x;
                check("sb8", 64'({o8, c8, 24'd0, s8}), 64'(e));
            end
            if (in_valid && r8) q8.push_back(model(op_a, op_b, cin, sub, 8));
        end
    end

    // Beats in flight are discarded by reset, so their expectations go too.
    always @(negedge reset_n) begin
        q32.delete();
        q16.delete();
        q8.delete();
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    task automatic drive(input vec_t v);
        op_a     = v.a;
        op_b     = v.b;
        cin      = v.c;
        sub      = v.s;
        in_valid = 1'b1;
    endtask

    task automatic drive_rand();
        op_a     = $urandom;
        op_b     = $urandom;
        cin      = 1'($urandom);
        sub      = 1'($urandom);
        in_valid = 1'b1;
    endtask

    task automatic check_out(input string nm, input vec_t v);
        check({nm, " out_valid"}, 64'(v32), 64'(1));
        check({nm, " SUM"}, 64'(s32), 64'(v.sum));
        check({nm, " cout"}, 64'(c32), 64'(v.co));
        check({nm, " ovf"}, 64'(o32), 64'(v.ov));
    endtask

    task automatic one_beat(input vec_t v, input int idx);
        @(posedge clk); #1;
        drive(v);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk); #1;
            if (k < LAT) check($sformatf("vec%0d early valid", idx), 64'(v32), 64'(0));
        end
        check_out($sformatf("vec%0d", idx), v);
    endtask

    task automatic run_seq(input int n, input string nm);
        int w;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            drive(seq[i]);
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        w = 0;
        while (v32 !== 1'b1 && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        check({nm, " first latency"}, 64'(w), 64'(LAT + 1 - n));
        for (int i = 0; i < n; i++) begin
            check_out($sformatf("%s[%0d]", nm, i), seq[i]);
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string nm);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check({nm, " q32 empty"}, 64'(q32.size()), 64'(0));
        check({nm, " q16 empty"}, 64'(q16.size()), 64'(0));
        check({nm, " q8 empty"}, 64'(q8.size()), 64'(0));
    endtask

    initial begin
        logic [33:0] e;
        int          cyc;
        int          start;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cin       = 1'b0;
        sub       = 1'b0;
        op_a      = '0;
        op_b      = '0;

        //          a              b              c     s     sum            co    ov
        tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[1] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[3] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
        tbl[4] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        tbl[6] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        tbl[7] = '{32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
        tbl[8] = '{32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[9] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

        // Held in reset while inputs toggle.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            drive_rand();
            out_ready = 1'($urandom);
            #1;
            check("rst out_valid", 64'(v32), 64'(0));
            check("rst SUM", 64'(s32), 64'(0));
            check("rst cout", 64'(c32), 64'(0));
            check("rst ovf", 64'(o32), 64'(0));
            check("rst in_ready", 64'(r32), 64'(1));
            check("rst out_valid16", 64'(v16), 64'(0));
            check("rst out_valid8", 64'(v8), 64'(0));
        end
        @(posedge clk); #2;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        reset_n   = 1'b1;

        for (int i = 0; i < 10; i++) one_beat(tbl[i], i);

        seq[0] = tbl[1]; seq[1] = tbl[2]; seq[2] = tbl[3];
        run_seq(3, "b2b");
        seq[0] = tbl[4]; seq[1] = tbl[1]; seq[2] = tbl[5]; seq[3] = tbl[3];
        run_seq(4, "mix");
        seq[0] = tbl[6]; seq[1] = tbl[0]; seq[2] = tbl[8]; seq[3] = tbl[9];
        run_seq(4, "mix2");
        drain("seq");

        // Backpressure: six beats, then a three-cycle stall with a result on the output.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive_rand();
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) begin
            e = (q32.size() > 0) ? q32[0] : 'x;
            check("stall in_ready", 64'(r32), 64'(0));
            check("stall out_valid", 64'(v32), 64'(1));
            check("stall result", 64'({o32, c32, s32}), 64'(e));
            @(posedge clk); #2;
        end
        check("stall q32 pending", 64'(q32.size()), 64'(5));
        drain("bp");

        // Reset asserted mid-stream, then a beat presented across the release.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            drive_rand();
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre-reset out_valid", 64'(v32), 64'(1));
        check("pre-reset out_valid8", 64'(v8), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check("async rst out_valid", 64'(v32), 64'(0));
        check("async rst SUM", 64'(s32), 64'(0));
        check("async rst in_ready", 64'(r32), 64'(1));
        check("async rst out_valid8", 64'(v8), 64'(0));
        check("async rst out_valid16", 64'(v16), 64'(0));
        drive(tbl[0]);
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                check("w8 valid", 64'(v8), 64'(1));
                check("w8 SUM", 64'(s8), 64'(0));
                check("w8 cout", 64'(c8), 64'(1));
            end
            if (k < LAT) check("post-rst stale", 64'(v32), 64'(0));
        end
        check_out("post-rst first", tbl[0]);
        check("w16 valid", 64'(v16), 64'(1));
        check("w16 SUM", 64'(s16), 64'(0));
        check("w16 cout", 64'(c16), 64'(1));
        @(posedge clk); #1;
        check("post-rst single", 64'(v32), 64'(0));
        drain("rst");

        // Random traffic with 50% in_valid and 50% out_ready.
        start = acc32;
        cyc   = 0;
        while (acc32 - start < 1000 && cyc < 20000) begin
            @(posedge clk); #1;
            drive_rand();
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            cyc++;
        end
        check("random beats accepted", 64'(acc32 - start >= 1000), 64'(1));
        drain("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
